collision_detect: RTL and testbench

Per-pixel collision detector that sits directly downstream of the goose sprite renderer. It consumes the renderer's `goose` coverage flag and the obstacle layer's coverage flag while the VGA scan is active. It counts overlapping pixels per frame and asserts `check_hit` once a frame's overlap reaches a threshold. That flag is fed back to the goose renderer and the score logic, and it stays asserted until the game is reset.

---
 rtl/collision_detect_if.sv | 23 ++
 rtl/collision_detect.sv | 115 +++++++++++
 tb/tb_collision_detect.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/collision_detect_if.sv
// Pixel-stream bus between the VGA scan/renderers and the collision detector,
// plus the detector's result signals fed back to the goose renderer and score logic.
interface collision_detect_if;
  logic [9:0] x;
  logic [9:0] y;
  logic       pix_en;
  logic       goose;
  logic       obstacle;
  logic       check_hit;
  logic [9:0] hit_x;
  logic [9:0] hit_y;
  logic       armed;

  modport master (
    output x, y, pix_en, goose, obstacle,
    input  check_hit, hit_x, hit_y, armed
  );

  modport slave (
    input  x, y, pix_en, goose, obstacle,
    output check_hit, hit_x, hit_y, armed
  );
endinterface

// File: rtl/collision_detect.sv
// Per-pixel goose/obstacle collision detector: counts overlaps per frame after a
// grace period and latches a sticky hit with the first overlapping pixel's location.
module collision_detect #(
  parameter int H_ACTIVE      = 640,
  parameter int V_ACTIVE      = 480,
  parameter int HIT_THRESHOLD = 4,
  parameter int GRACE_FRAMES  = 60
) (
  input logic          clk,
  input logic          reset,
  collision_detect_if.slave pix
);

  typedef enum logic [1:0] {GRACE, ARMED, HIT} state_t;

  localparam logic [9:0]  H_LIM      = 10'(H_ACTIVE);
  localparam logic [9:0]  V_LIM      = 10'(V_ACTIVE);
  localparam logic [9:0]  H_LAST     = 10'(H_ACTIVE - 1);
  localparam logic [9:0]  V_LAST     = 10'(V_ACTIVE - 1);
  localparam logic [15:0] THRESH     = 16'(HIT_THRESHOLD);
  localparam logic [7:0]  GRACE_INIT = 8'(GRACE_FRAMES);
  localparam state_t      RESET_STATE = (GRACE_FRAMES == 0) ? ARMED : GRACE;
  localparam logic        RESET_ARMED = (GRACE_FRAMES == 0);

  state_t      state, state_n;
  logic [7:0]  grace_cnt, grace_cnt_n;
  logic [15:0] ovl_cnt, ovl_cnt_n, ovl_inc;
  logic [9:0]  first_x, first_y, first_x_n, first_y_n;
  logic [9:0]  hit_x_q, hit_y_q, hit_x_n, hit_y_n;
  logic        check_hit_q, armed_q;
  logic        sample, overlap, frame_end;

  always_comb begin
    sample    = pix.pix_en && (pix.x < H_LIM) && (pix.y < V_LIM);
    overlap   = sample && pix.goose && pix.obstacle;
    frame_end = pix.pix_en && (pix.x == H_LAST) && (pix.y == V_LAST);
    ovl_inc   = (ovl_cnt == 16'hFFFF) ? ovl_cnt : ovl_cnt + 16'd1;
  end

  // Next-state logic; an overlap on the frame-end pixel is folded into the count
  // before the threshold compare, and the per-frame count always clears at frame end.
  always_comb begin
    state_n     = state;
    grace_cnt_n = grace_cnt;
    ovl_cnt_n   = ovl_cnt;
    first_x_n   = first_x;
    first_y_n   = first_y;
    hit_x_n     = hit_x_q;
    hit_y_n     = hit_y_q;
    case (state)
      GRACE: begin
        if (frame_end) begin
          if (grace_cnt <= 8'd1) state_n = ARMED;
          else                   grace_cnt_n = grace_cnt - 8'd1;
        end
      end
      ARMED: begin
        if (overlap) begin
          ovl_cnt_n = ovl_inc;
          if (ovl_cnt == 16'd0) begin
            first_x_n = pix.x;
            first_y_n = pix.y;
          end
        end
        if (frame_end) begin
          if (ovl_cnt_n >= THRESH) begin
            state_n = HIT;
            hit_x_n = first_x_n;
            hit_y_n = first_y_n;
          end
          ovl_cnt_n = 16'd0;
          first_x_n = 10'd0;
          first_y_n = 10'd0;
        end
      end
      HIT: begin
        state_n = HIT;
      end
      default: begin
        state_n = RESET_STATE;
      end
    endcase
  end

  // Reset wins over any simultaneous frame end, including one that would hit.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RESET_STATE;
      grace_cnt   <= GRACE_INIT;
      ovl_cnt     <= 16'd0;
      first_x     <= 10'd0;
      first_y     <= 10'd0;
      hit_x_q     <= 10'd0;
      hit_y_q     <= 10'd0;
      check_hit_q <= 1'b0;
      armed_q     <= RESET_ARMED;
    end else begin
      state       <= state_n;
      grace_cnt   <= grace_cnt_n;
      ovl_cnt     <= ovl_cnt_n;
      first_x     <= first_x_n;
      first_y     <= first_y_n;
      hit_x_q     <= hit_x_n;
      hit_y_q     <= hit_y_n;
      check_hit_q <= (state_n == HIT);
      armed_q     <= (state_n == ARMED);
    end
  end

  assign pix.check_hit = check_hit_q;
  assign pix.hit_x     = hit_x_q;
  assign pix.hit_y     = hit_y_q;
  assign pix.armed     = armed_q;

endmodule

// File: tb/tb_collision_detect.sv
// Directed bench for collision_detect with GRACE_FRAMES=2 and HIT_THRESHOLD=4;
// frames are abbreviated by jumping straight to the frame-end pixel.
module tb_collision_detect;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  collision_detect_if bus();

  collision_detect #(
    .H_ACTIVE(640),
    .V_ACTIVE(480),
    .HIT_THRESHOLD(4),
    .GRACE_FRAMES(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .pix(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Drives one pixel for exactly one cycle; returns at the following negedge,
  // where the result of that pixel is already visible on the registered outputs.
  task automatic applyStimulus(input int px, input int py, input logic g, input logic o);
    bus.x        = 10'(px);
    bus.y        = 10'(py);
    bus.goose    = g;
    bus.obstacle = o;
    bus.pix_en   = 1'b1;
    @(negedge clk);
    bus.pix_en   = 1'b0;
  endtask

  task automatic idleCycles(input int n, input logic g, input logic o);
    bus.goose    = g;
    bus.obstacle = o;
    bus.pix_en   = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic doReset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic overlapRun(input int px, input int py, input int n);
    for (int i = 0; i < n; i++) applyStimulus(px + i, py, 1'b1, 1'b1);
  endtask

  task automatic checkAll(input string tag, input logic hit, input int hx, input int hy, input logic arm);
    checkOutput({tag, ".check_hit"}, 32'(bus.check_hit), 32'(hit));
    checkOutput({tag, ".hit_x"},     32'(bus.hit_x),     32'(hx));
    checkOutput({tag, ".hit_y"},     32'(bus.hit_y),     32'(hy));
    checkOutput({tag, ".armed"},     32'(bus.armed),     32'(arm));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b0;
    bus.x = '0; bus.y = '0; bus.pix_en = 1'b0; bus.goose = 1'b0; bus.obstacle = 1'b0;
    @(negedge clk);
    doReset();
    checkAll("reset", 1'b0, 0, 0, 1'b0);

    // Grace: overlaps ignored; the final grace E carries an overlap that must not count.
    overlapRun(100, 100, 10);
    applyStimulus(639, 479, 1'b0, 1'b0);
    checkAll("grace1", 1'b0, 0, 0, 1'b0);
    overlapRun(200, 150, 10);
    applyStimulus(639, 479, 1'b1, 1'b1);
    checkAll("grace2", 1'b0, 0, 0, 1'b1);

    // Three overlaps are below threshold; four in the next frame hit.
    overlapRun(100, 200, 3);
    applyStimulus(639, 479, 1'b0, 1'b1);
    checkAll("three", 1'b0, 0, 0, 1'b1);
    overlapRun(50, 380, 4);
    checkOutput("pre_e.check_hit", 32'(bus.check_hit), 32'd0);
    applyStimulus(639, 479, 1'b1, 1'b0);
    checkAll("four", 1'b1, 50, 380, 1'b0);

    // HIT absorbs further overlaps and frame ends.
    overlapRun(300, 20, 6);
    applyStimulus(639, 479, 1'b1, 1'b1);
    checkAll("absorb", 1'b1, 50, 380, 1'b0);

    // Mid-frame reset from HIT; the partial frame's E is grace frame 1.
    overlapRun(10, 5, 2);
    doReset();
    checkAll("hit_reset", 1'b0, 0, 0, 1'b0);
    overlapRun(20, 30, 5);
    applyStimulus(639, 479, 1'b0, 1'b0);
    checkAll("partial_e", 1'b0, 0, 0, 1'b0);
    applyStimulus(639, 479, 1'b0, 1'b0);
    checkAll("rearm", 1'b0, 0, 0, 1'b1);

    // Counts clear at each E, with sparse pix_en between pixels.
    for (int f = 0; f < 2; f++) begin
      applyStimulus(30, 40, 1'b1, 1'b1);
      idleCycles(3, 1'b1, 1'b1);
      applyStimulus(31, 40, 1'b1, 1'b1);
      idleCycles(3, 1'b0, 1'b0);
      applyStimulus(639, 479, 1'b0, 1'b0);
      checkOutput("split.check_hit", 32'(bus.check_hit), 32'd0);
    end

    // Idle cycles and off-screen pixels contribute nothing; then 3 real overlaps stay below threshold.
    idleCycles(10, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) applyStimulus(700, 100 + i, 1'b1, 1'b1);
    applyStimulus(100, 480, 1'b1, 1'b1);
    applyStimulus(640, 479, 1'b1, 1'b1);
    checkOutput("offscreen_e.check_hit", 32'(bus.check_hit), 32'd0);
    overlapRun(60, 60, 3);
    applyStimulus(639, 479, 1'b0, 1'b0);
    checkAll("offscreen", 1'b0, 0, 0, 1'b1);

    // Overlap on the E pixel completes the threshold.
    overlapRun(10, 10, 3);
    applyStimulus(639, 479, 1'b1, 1'b1);
    checkAll("e_overlap", 1'b1, 10, 10, 1'b0);

    // Same again but reset coincides with the qualifying E.
    doReset();
    applyStimulus(639, 479, 1'b0, 1'b0);
    applyStimulus(639, 479, 1'b0, 1'b0);
    checkOutput("rearm2.armed", 32'(bus.armed), 32'd1);
    overlapRun(10, 10, 3);
    reset = 1'b1;
    applyStimulus(639, 479, 1'b1, 1'b1);
    reset = 1'b0;
    checkAll("reset_on_e", 1'b0, 0, 0, 1'b0);
    applyStimulus(639, 479, 1'b0, 1'b0);
    checkOutput("post_reset_g1.armed", 32'(bus.armed), 32'd0);
    applyStimulus(639, 479, 1'b0, 1'b0);
    checkOutput("post_reset_g2.armed", 32'(bus.armed), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
